acc_stream_driver: RTL and testbench

- Initiator side of the accumulator Load/Data_In/Done interface.
- Buffers host words in an internal FIFO. On start, it issues a one-cycle Load pulse and streams BURST_LEN words, one per cycle. It then waits for Done, captures ACC_Out and returns the result over a valid/ready port.
- Sits between the host/test logic and the ControlPath/Data_Path accumulator pair.

---
 rtl/acc_stream_driver.sv | 109 ++++++++++
 tb/tb_acc_stream_driver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/acc_stream_driver.sv
// acc_stream_driver: FIFO-buffered initiator that bursts words into an accumulator and returns its result
module acc_stream_driver #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     start,
    output logic                     acc_load,
    output logic [DATA_W-1:0]        acc_data,
    input  logic                     acc_done,
    input  logic [DATA_W-1:0]        acc_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [DATA_W-1:0]        res_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     err_underrun,
    output logic                     err_timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [CW-1:0] BL        = CW'(BURST_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, STREAM, WAIT_DONE, RESULT} state_t;

    state_t            state, nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     cnt_nxt;
    logic [BW-1:0]     beat;
    logic [TW-1:0]     tick;
    logic              push, pop, underrun, timeout;

    // next-state decode; outputs are registered from nxt so they line up with the state they describe
    always_comb begin
        nxt      = state;
        underrun = 1'b0;
        timeout  = 1'b0;
        case (state)
            IDLE:      if (start) begin
                           if (fifo_count >= BL) nxt = LOAD;
                           else underrun = 1'b1;
                       end
            LOAD:      nxt = STREAM;
            STREAM:    if (beat == '0) nxt = WAIT_DONE;
            WAIT_DONE: if (acc_done) nxt = RESULT;
                       else if (tick == LAST_TICK) begin
                           nxt     = IDLE;
                           timeout = 1'b1;
                       end
            RESULT:    if (res_ready) nxt = IDLE;
            default:   nxt = IDLE;
        endcase
        push    = wr_valid && wr_ready;
        pop     = nxt == STREAM;
        cnt_nxt = fifo_count + CW'(push) - CW'(pop);
    end

    // FIFO storage needs no reset: only entries below fifo_count are ever read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // state, FIFO bookkeeping, burst/timeout counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            wr_ready     <= 1'b1;
            beat         <= '0;
            tick         <= '0;
            acc_load     <= 1'b0;
            acc_data     <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            busy         <= 1'b0;
            err_underrun <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= nxt;
            wr_ptr       <= wr_ptr + AW'(push);
            rd_ptr       <= rd_ptr + AW'(pop);
            fifo_count   <= cnt_nxt;
            wr_ready     <= cnt_nxt != FULL;
            beat         <= state == STREAM ? beat - 1'b1 : LAST_BEAT;
            tick         <= state == WAIT_DONE ? tick + 1'b1 : '0;
            acc_load     <= nxt == LOAD;
            acc_data     <= pop ? mem[rd_ptr] : '0;
            res_valid    <= nxt == RESULT;
            res_data     <= (state == WAIT_DONE && acc_done) ? acc_result : res_data;
            busy         <= nxt != IDLE;
            err_underrun <= underrun;
            err_timeout  <= timeout;
        end
    end
endmodule

// File: tb/tb_acc_stream_driver.sv
// tb_acc_stream_driver: table vectors, directed corner cases and randomized run against a timeline model
module tb_acc_stream_driver;
    localparam int DW = 8, DEPTH = 16, BL = 4, TO = 64;

    logic clk = 0, rst = 0, wr_valid = 0, start = 0, acc_done = 0, res_ready = 0;
    logic [DW-1:0] wr_data = 0, acc_result = 0;
    logic wr_ready, acc_load, res_valid, busy, err_underrun, err_timeout;
    logic [DW-1:0] acc_data, res_data;
    logic [4:0] fifo_count;

    int n_cmp = 0, n_bad = 0;

    acc_stream_driver #(.DATA_W(DW), .DEPTH(DEPTH), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .start(start), .acc_load(acc_load), .acc_data(acc_data), .acc_done(acc_done),
        .acc_result(acc_result), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .fifo_count(fifo_count), .err_underrun(err_underrun), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // timeline model: a burst accepted at edge c0 loads at c0, streams at c0+1..c0+BL,
    // waits from c0+BL+1 and samples Done on the following TO edges
    logic [DW-1:0] q[$];
    int c, c0;
    bit act, got, m_ld, m_eu, m_et;
    logic [DW-1:0] m_ad, m_rd;

    task automatic model_clear();
        q.delete();
        c = 0; c0 = -1000; act = 0; got = 0; m_rd = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_load"}, acc_load, 0);
        chk({tag, "_data"}, acc_data, 0);
        chk({tag, "_rvalid"}, res_valid, 0);
        chk({tag, "_rdata"}, res_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_count"}, fifo_count, 0);
        chk({tag, "_wready"}, wr_ready, 1);
        chk({tag, "_underrun"}, err_underrun, 0);
        chk({tag, "_timeout"}, err_timeout, 0);
    endtask

    task automatic do_reset();
        wr_valid = 0; start = 0; acc_done = 0; res_ready = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 check_reset("rst");
        rst = 0;
        model_clear();
    endtask

    task automatic cyc(input bit wv, input logic [DW-1:0] wd, input bit st, input bit dn,
                       input logic [DW-1:0] dr, input bit rr);
        bit acc_w;
        wr_valid = wv; wr_data = wd; start = st; acc_done = dn; acc_result = dr; res_ready = rr;
        @(posedge clk);
        #1;
        acc_w = wv && (q.size() != DEPTH);
        c++;
        m_ld = 0; m_eu = 0; m_et = 0; m_ad = 0;
        if (got) begin
            if (rr) begin got = 0; act = 0; end
        end else if (act) begin
            if (c >= c0 + BL + 2 && dn) begin got = 1; m_rd = dr; end
            else if (c == c0 + BL + 1 + TO) begin m_et = 1; act = 0; end
            if (c >= c0 + 1 && c <= c0 + BL) m_ad = q.pop_front();
        end else if (st) begin
            if (q.size() >= BL) begin act = 1; c0 = c; m_ld = 1; end
            else m_eu = 1;
        end
        if (acc_w) q.push_back(wd);
        chk("m_load", acc_load, m_ld);
        chk("m_data", acc_data, m_ad);
        chk("m_busy", busy, act);
        chk("m_rvalid", res_valid, got);
        chk("m_rdata", res_data, m_rd);
        chk("m_count", fifo_count, q.size());
        chk("m_wready", wr_ready, q.size() != DEPTH);
        chk("m_underrun", err_underrun, m_eu);
        chk("m_timeout", err_timeout, m_et);
    endtask

    typedef struct {
        logic wv; logic [7:0] wd; logic st; logic dn; logic [7:0] dr; logic rr;
        logic ld; logic [7:0] ad; logic rv; logic [7:0] rd; logic bz; logic [4:0] fc; logic wrr; logic eu;
    } vec_t;
    vec_t tbl[22];

    initial begin
        logic [DW-1:0] fill[16];
        logic [DW-1:0] burst1[4];
        int seen;
        // wv wd  st dn dr  rr | ld ad rv rd bz fc wr eu
        tbl[0]  = '{1, 8'h01, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 5'd1, 1, 0};
        tbl[1]  = '{1, 8'h02, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 5'd2, 1, 0};
        tbl[2]  = '{1, 8'h04, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 5'd3, 1, 0};
        tbl[3]  = '{1, 8'h08, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 5'd4, 1, 0};
        tbl[4]  = '{0, 8'h00, 1, 0, 8'h00, 0, 1, 8'h00, 0, 8'h00, 1, 5'd4, 1, 0};
        tbl[5]  = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h01, 0, 8'h00, 1, 5'd3, 1, 0};
        tbl[6]  = '{0, 8'h00, 0, 1, 8'h55, 0, 0, 8'h02, 0, 8'h00, 1, 5'd2, 1, 0};
        tbl[7]  = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h04, 0, 8'h00, 1, 5'd1, 1, 0};
        tbl[8]  = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h08, 0, 8'h00, 1, 5'd0, 1, 0};
        tbl[9]  = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 1, 5'd0, 1, 0};
        tbl[10] = '{0, 8'h00, 0, 1, 8'h0F, 0, 0, 8'h00, 1, 8'h0F, 1, 5'd0, 1, 0};
        for (int i = 11; i < 16; i++)
            tbl[i] = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h0F, 1, 5'd0, 1, 0};
        tbl[16] = '{0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h0F, 0, 5'd0, 1, 0};
        tbl[17] = '{1, 8'h10, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h0F, 0, 5'd1, 1, 0};
        tbl[18] = '{1, 8'h20, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h0F, 0, 5'd2, 1, 0};
        tbl[19] = '{1, 8'h30, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h0F, 0, 5'd3, 1, 0};
        tbl[20] = '{0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h0F, 0, 5'd3, 1, 1};
        tbl[21] = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h0F, 0, 5'd3, 1, 0};

        do_reset();
        for (int i = 0; i < 22; i++) begin
            wr_valid = tbl[i].wv; wr_data = tbl[i].wd; start = tbl[i].st;
            acc_done = tbl[i].dn; acc_result = tbl[i].dr; res_ready = tbl[i].rr;
            @(posedge clk);
            #1;
            chk($sformatf("t%0d_load", i), acc_load, tbl[i].ld);
            chk($sformatf("t%0d_data", i), acc_data, tbl[i].ad);
            chk($sformatf("t%0d_rvalid", i), res_valid, tbl[i].rv);
            chk($sformatf("t%0d_rdata", i), res_data, tbl[i].rd);
            chk($sformatf("t%0d_busy", i), busy, tbl[i].bz);
            chk($sformatf("t%0d_count", i), fifo_count, tbl[i].fc);
            chk($sformatf("t%0d_wready", i), wr_ready, tbl[i].wrr);
            chk($sformatf("t%0d_underrun", i), err_underrun, tbl[i].eu);
        end

        // fill to full, drop a 17th word, then stream the 4 oldest while writing
        do_reset();
        for (int i = 0; i < 16; i++) begin
            fill[i] = 8'(i * 17 + 3);
            cyc(1, fill[i], 0, 0, 0, 0);
        end
        chk("full_wready", wr_ready, 0);
        chk("full_count", fifo_count, 16);
        cyc(1, 8'hEE, 0, 0, 0, 0);
        chk("drop17_count", fifo_count, 16);
        cyc(0, 0, 1, 0, 0, 0);
        chk("full_load", acc_load, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("full_beat0", acc_data, fill[0]);
        for (int b = 1; b < BL; b++) begin
            cyc(1, 8'(8'hA0 + b), 0, 0, 0, 0);
            chk($sformatf("full_beat%0d", b), acc_data, fill[b]);
        end
        chk("full_after_count", fifo_count, 12 + BL - 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 8'h77, 0);
        chk("full_rdata", res_data, 8'h77);
        cyc(0, 0, 0, 0, 0, 1);

        // Done never arrives: timeout 64 edges after WAIT_DONE is entered
        cyc(0, 0, 1, 0, 0, 0);
        for (int b = 0; b <= BL; b++) cyc(0, 0, 0, 0, 0, 0);
        chk("wait_busy", busy, 1);
        seen = 0;
        for (int k = 1; k <= TO + 16; k++) begin
            cyc(0, 0, 0, 0, 0, 0);
            if (err_timeout && seen == 0) seen = k;
        end
        chk("timeout_cycle", seen, TO);
        chk("timeout_rvalid", res_valid, 0);
        chk("timeout_busy", busy, 0);

        // asynchronous reset two beats into a burst
        do_reset();
        burst1[0] = 8'h01; burst1[1] = 8'h02; burst1[2] = 8'h04; burst1[3] = 8'h08;
        for (int i = 0; i < 4; i++) cyc(1, burst1[i], 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("pre_rst_data", acc_data, 8'h02);
        #2 rst = 1;
        #1 check_reset("async");
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, burst1[i], 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("post_load", acc_load, 1);
        for (int b = 0; b < BL; b++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk($sformatf("post_beat%0d", b), acc_data, burst1[b]);
        end
        chk("post_count", fifo_count, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 8'h0F, 0);
        chk("post_rvalid", res_valid, 1);
        chk("post_rdata", res_data, 8'h0F);
        cyc(0, 0, 0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++)
            cyc(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 5) == 0,
                $urandom_range(0, 49) == 0, 8'($urandom), $urandom_range(0, 2) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
